i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, word-address pointer width; only value 8 is supported.
REQ-002 SHALL have port: clk  input  1  system clock; clk frequency >= 20x SCL frequency.
REQ-003 SHALL have port: rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port: dev_addr  input  7  own 7-bit target address; static while not idle.
REQ-005 SHALL have port: scl_i  input  1  raw SCL from pad; asynchronous.
REQ-006 SHALL have port: sda_i  input  1  raw SDA from pad; asynchronous.
REQ-007 SHALL have port: sda_oe  output  1  1 = pull SDA low; pad drives 1'bz otherwise.
REQ-008 SHALL have port: wr_en  output  1  one-cycle pulse; wr_addr/wr_data valid.
REQ-009 SHALL have port: wr_addr  output  8  write word address.
REQ-010 SHALL have port: wr_data  output  8  write byte.
REQ-011 SHALL have port: rd_req  output  1  one-cycle pulse requesting byte at rd_addr.
REQ-012 SHALL have port: rd_addr  output  8  read word address.
REQ-013 SHALL have port: rd_data  input  8  read byte, valid exactly 1 clk after rd_req.
REQ-014 SHALL have port: busy  output  1  high from addressed START until STOP/mismatch.

Function
REQ-015 SHALL synchronise scl_i/sda_i through 2 flops and detect SCL rise/fall and SDA edges on synchronised values.
REQ-016 SHALL detect START (Sr included) as SDA fall while SCL high, STOP as SDA rise while SCL high; both take priority over bit handling in any state.
REQ-017 SHALL sample SDA on SCL rise and change sda_oe only 1 clk after SCL fall.
REQ-018 SHALL use states IDLE, DEV, DEV_ACK, WORD, WORD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-019 START -> DEV; 8 bits shifted MSB first; on 8th fall, {dev_addr,x} match -> DEV_ACK (sda_oe=1 for 9th bit), mismatch -> WAIT_STOP with sda_oe=0.
REQ-020 DEV_ACK with R/W=0 -> WORD; R/W=1 -> RDATA using current pointer.
REQ-021 WORD receives pointer byte, ACKs it, -> WDATA; every WDATA byte is ACKed, pulses wr_en with wr_addr=pointer at 8th SCL rise+1 clk, then pointer increments.
REQ-022 Pointer SHALL wrap 0xFF -> 0x00 and persist across transactions until reset.
REQ-023 Read: rd_req pulses on the ACK-bit SCL rise (or DEV_ACK rise), rd_data loaded into shift register next clk, MSB driven after that ACK SCL fall; pointer increments after each rd_req.
REQ-024 RDATA drives sda_oe = ~bit; RDATA_ACK releases SDA and samples master ACK: ACK(0) -> next byte, NACK(1) -> WAIT_STOP with no further rd_req.
REQ-025 WAIT_STOP SHALL keep sda_oe=0 until STOP -> IDLE or START -> DEV.
REQ-026 STOP or START mid-byte SHALL abort the byte: no wr_en, sda_oe=0 within 1 clk.
REQ-027 busy SHALL rise at address match and fall at STOP, mismatch or NACK.

Reset
REQ-028 On rst: state=IDLE, pointer=0x00, sda_oe=0, wr_en=0, rd_req=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, synchroniser flops=1.
REQ-029 rst asserted mid-transaction SHALL release SDA in the next clk; bus activity is ignored until the next START.

Configuration
REQ-030 Macro I2C_TARGET_GLITCH_FILTER_EN defined: synchronised SCL/SDA SHALL pass a 3-sample majority filter (+2 clk detection latency, pulses <2 clk rejected).
REQ-031 Macro undefined: no filter; edge detection latency is exactly 2 clk from pad.

Verification
REQ-032 dev_addr=0x50; master writes 0xA0,0x10,0x3C,0x5A,STOP -> 4 ACKs; wr_en at 0x10=0x3C, 0x11=0x5A; busy low after STOP.
REQ-033 Write 0xA0,0x20; Sr; 0xA1; read 3 bytes, NACK last; rd_data=addr^0xFF -> rd_req at 0x20,0x21,0x22; bus bytes 0xDF,0xDE,0xDD; no 4th rd_req.
REQ-034 Write 0xA0,0xFF,0x11,0x22 -> wr_en at 0xFF=0x11, 0x00=0x22.
REQ-035 Master sends 0xA4 (addr 0x52) -> no ACK, sda_oe never 1, busy 0, no wr_en/rd_req.
REQ-036 STOP after 4 bits of WDATA byte -> no wr_en, IDLE; rst asserted during RDATA -> sda_oe=0 next clk, pointer=0x00.
REQ-037 With I2C_TARGET_GLITCH_FILTER_EN: 1-clk SCL low glitch during WDATA -> byte still 0x3C, no extra bit shifted.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target (7-bit address) exposing an 8-bit word-addressed register port.
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_target #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        dev_addr,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, WORD, WORD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  state_t            state, state_d;
  logic [1:0]        scl_s, sda_s;
  logic              scl, sda, scl_q, sda_q;
  logic              scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]        shreg;
  logic [3:0]        cnt;
  logic              rw, rd_req_q;
  logic [ADDR_W-1:0] ptr;
  logic              addr_hit;
  logic              sda_oe_d, busy_d, wr_fire, rd_fire;

  // Pads are asynchronous: two-flop synchronisers, idle-high after reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
    end else begin
      scl_s <= {scl_s[0], scl_i};
      sda_s <= {sda_s[0], sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  logic       scl_f, sda_f;

  // Majority of the last three synchronised samples rejects single-clock pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_s[1]};
      sda_h <= {sda_h[0], sda_s[1]};
      scl_f <= (scl_s[1] & scl_h[0]) | (scl_s[1] & scl_h[1]) | (scl_h[0] & scl_h[1]);
      sda_f <= (sda_s[1] & sda_h[0]) | (sda_s[1] & sda_h[1]) | (sda_h[0] & sda_h[1]);
    end
  end

  assign scl = scl_f;
  assign sda = sda_f;
`else
  assign scl = scl_s[1];
  assign sda = sda_s[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;
  assign addr_hit  = (shreg[7:1] == dev_addr);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    if (start_det)     state_d = DEV;
    else if (stop_det) state_d = IDLE;
    else begin
      case (state)
        DEV:       if (scl_fall && cnt == 4'd8) state_d = addr_hit ? DEV_ACK : WAIT_STOP;
        DEV_ACK:   if (scl_fall) state_d = rw ? RDATA : WORD;
        WORD:      if (scl_fall && cnt == 4'd8) state_d = WORD_ACK;
        WORD_ACK:  if (scl_fall) state_d = WDATA;
        WDATA:     if (scl_fall && cnt == 4'd8) state_d = WDATA_ACK;
        WDATA_ACK: if (scl_fall) state_d = WDATA;
        RDATA:     if (scl_fall && cnt == 4'd8) state_d = RDATA_ACK;
        RDATA_ACK: begin
          if (scl_rise && sda) state_d = WAIT_STOP;
          else if (scl_fall)   state_d = RDATA;
        end
        default:   state_d = state;
      endcase
    end
  end

  // SDA only moves on an SCL fall, so the registered sda_oe lags that fall by one clk.
  always_comb begin
    sda_oe_d = sda_oe;
    busy_d   = busy;
    wr_fire  = 1'b0;
    rd_fire  = 1'b0;
    if (stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      sda_oe_d = 1'b0;
    end else begin
      case (state)
        DEV: if (scl_fall && cnt == 4'd8) begin
          sda_oe_d = addr_hit;
          busy_d   = addr_hit;
        end
        DEV_ACK: begin
          if (scl_rise && rw) rd_fire = 1'b1;
          if (scl_fall) sda_oe_d = rw ? ~shreg[7] : 1'b0;
        end
        WORD, WDATA: begin
          if (state == WDATA && scl_rise && cnt == 4'd7) wr_fire = 1'b1;
          if (scl_fall && cnt == 4'd8) sda_oe_d = 1'b1;
        end
        WORD_ACK, WDATA_ACK: if (scl_fall) sda_oe_d = 1'b0;
        RDATA: if (scl_fall) sda_oe_d = (cnt == 4'd8) ? 1'b0 : ~shreg[7];
        RDATA_ACK: begin
          if (scl_rise && !sda) rd_fire = 1'b1;
          if (scl_rise && sda)  busy_d  = 1'b0;
          if (scl_fall)         sda_oe_d = ~shreg[7];
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_en    <= 1'b0;
      rd_req   <= 1'b0;
      rd_req_q <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_addr  <= '0;
      ptr      <= '0;
      shreg    <= '0;
      cnt      <= '0;
      rw       <= 1'b0;
    end else begin
      sda_oe   <= sda_oe_d;
      busy     <= busy_d;
      wr_en    <= wr_fire;
      rd_req   <= rd_fire;
      rd_req_q <= rd_req;

      // Bit counter restarts on every state change and on any START.
      if (start_det || state_d != state) cnt <= '0;
      else if (scl_rise)                 cnt <= cnt + 4'd1;

      // Read data arrives one clk after rd_req and replaces the shifted-in bits.
      if (rd_req_q)      shreg <= rd_data;
      else if (scl_rise) shreg <= {shreg[6:0], sda};

      if (state == DEV && state_d == DEV_ACK) rw <= shreg[0];

      if (state == WORD && state_d == WORD_ACK) begin
        ptr <= ADDR_W'(shreg);
      end else if (wr_fire) begin
        wr_addr <= ptr;
        wr_data <= {shreg[6:0], sda};
        ptr     <= ptr + 1'b1;
      end else if (rd_fire) begin
        rd_addr <= ptr;
        ptr     <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bit-banged I2C master plus a scoreboard
// of expected wr_en / rd_req events popped as the target produces them.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] dev_addr = 7'h50;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, wr_en, rd_req, busy;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data = 8'h00;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [15:0] e_wr;
  logic [7:0]  e_rd;
  logic        oe_seen = 1'b0;
  logic        ack;
  logic [7:0]  rbyte;

  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_target #(.ADDR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .dev_addr (dev_addr),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register-file model: rd_data valid one clk after rd_req.
  always @(posedge clk) if (rd_req) rd_data <= rd_addr ^ 8'hFF;

  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (wr_en) begin
      if (exp_wr.size() == 0) check("wr_unexpected", 32'({wr_addr, wr_data}), 32'hFFFF_FFFF);
      else begin
        e_wr = exp_wr.pop_front();
        check("wr_event", 32'({wr_addr, wr_data}), 32'(e_wr));
      end
    end
    if (rd_req) begin
      if (exp_rd.size() == 0) check("rd_unexpected", 32'(rd_addr), 32'hFFFF_FFFF);
      else begin
        e_rd = exp_rd.pop_front();
        check("rd_event", 32'(rd_addr), 32'(e_rd));
      end
    end
  end

  task automatic wait_q();
    repeat (10) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, input bit glitch, output logic s);
    sda_m = b;
    wait_q();
    scl_m = 1'b1;
    repeat (5) @(negedge clk);
    if (glitch) begin
      scl_m = 1'b0;
      @(negedge clk);
      scl_m = 1'b1;
    end
    repeat (5) @(negedge clk);
    s = sda_bus;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b1;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic a);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], (i == glitch_bit), s);
    xfer_bit(1'b1, 1'b0, a);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, 1'b0, s);
      b = {b[6:0], s};
    end
    xfer_bit(nack, 1'b0, s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (4) @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_wr_en",  32'(wr_en),  32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_addrs",  32'({wr_addr, wr_data, rd_addr}), 32'd0);
    rst = 1'b0;
    wait_q();

    // Write two bytes starting at 0x10.
    exp_wr.push_back(16'h103C);
    exp_wr.push_back(16'h115A);
    i2c_start();
    write_byte(8'hA0, -1, ack); check("w1_dev_ack", 32'(ack), 32'd0);
    check("w1_busy", 32'(busy), 32'd1);
    write_byte(8'h10, -1, ack); check("w1_word_ack", 32'(ack), 32'd0);
    write_byte(8'h3C, -1, ack); check("w1_d0_ack", 32'(ack), 32'd0);
    write_byte(8'h5A, -1, ack); check("w1_d1_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_q();
    check("w1_busy_after_stop", 32'(busy), 32'd0);
    check("w1_wr_left", 32'(exp_wr.size()), 32'd0);

    // Set pointer 0x20, repeated start, read three bytes, NACK the last.
    exp_rd.push_back(8'h20);
    exp_rd.push_back(8'h21);
    exp_rd.push_back(8'h22);
    i2c_start();
    write_byte(8'hA0, -1, ack); check("r1_dev_ack", 32'(ack), 32'd0);
    write_byte(8'h20, -1, ack); check("r1_word_ack", 32'(ack), 32'd0);
    i2c_start();
    write_byte(8'hA1, -1, ack); check("r1_rdev_ack", 32'(ack), 32'd0);
    read_byte(1'b0, rbyte); check("r1_byte0", 32'(rbyte), 32'hDF);
    read_byte(1'b0, rbyte); check("r1_byte1", 32'(rbyte), 32'hDE);
    read_byte(1'b1, rbyte); check("r1_byte2", 32'(rbyte), 32'hDD);
    wait_q();
    check("r1_busy_after_nack", 32'(busy), 32'd0);
    i2c_stop();
    wait_q();
    check("r1_rd_left", 32'(exp_rd.size()), 32'd0);

    // Pointer wrap 0xFF -> 0x00.
    exp_wr.push_back(16'hFF11);
    exp_wr.push_back(16'h0022);
    i2c_start();
    write_byte(8'hA0, -1, ack); check("wrap_dev_ack", 32'(ack), 32'd0);
    write_byte(8'hFF, -1, ack); check("wrap_word_ack", 32'(ack), 32'd0);
    write_byte(8'h11, -1, ack); check("wrap_d0_ack", 32'(ack), 32'd0);
    write_byte(8'h22, -1, ack); check("wrap_d1_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_q();
    check("wrap_wr_left", 32'(exp_wr.size()), 32'd0);

    // Foreign address 0x52: no ACK, SDA never pulled, not busy.
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'hA4, -1, ack); check("miss_dev_nack", 32'(ack), 32'd1);
    check("miss_busy", 32'(busy), 32'd0);
    write_byte(8'h55, -1, ack); check("miss_data_nack", 32'(ack), 32'd1);
    i2c_stop();
    wait_q();
    check("miss_oe_seen", 32'(oe_seen), 32'd0);

    // STOP after four bits of a data byte: byte dropped, pointer unchanged.
    i2c_start();
    write_byte(8'hA0, -1, ack); check("abort_dev_ack", 32'(ack), 32'd0);
    write_byte(8'h30, -1, ack); check("abort_word_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) xfer_bit(logic'(i % 2 == 0), 1'b0, ack);
    i2c_stop();
    wait_q();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_oe", 32'(sda_oe), 32'd0);
    exp_rd.push_back(8'h30);
    i2c_start();
    write_byte(8'hA1, -1, ack); check("abort_rdev_ack", 32'(ack), 32'd0);
    read_byte(1'b1, rbyte); check("abort_rbyte", 32'(rbyte), 32'hCF);
    i2c_stop();
    wait_q();

    // Reset while driving a 0 data bit during a read.
    exp_rd.push_back(8'h80);
    i2c_start();
    write_byte(8'hA0, -1, ack); check("rst_dev_ack", 32'(ack), 32'd0);
    write_byte(8'h80, -1, ack); check("rst_word_ack", 32'(ack), 32'd0);
    i2c_start();
    write_byte(8'hA1, -1, ack); check("rst_rdev_ack", 32'(ack), 32'd0);
    check("rst_drive_before", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_oe_next_clk", 32'(sda_oe), 32'd0);
    check("rst_busy_mid", 32'(busy), 32'd0);
    rst = 1'b0;
    i2c_stop();
    exp_rd.push_back(8'h00);
    i2c_start();
    write_byte(8'hA1, -1, ack); check("rst_post_dev_ack", 32'(ack), 32'd0);
    read_byte(1'b1, rbyte); check("rst_post_rbyte", 32'(rbyte), 32'hFF);
    i2c_stop();
    wait_q();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // One-clk SCL low glitch inside a data bit must not add a bit.
    exp_wr.push_back(16'h103C);
    i2c_start();
    write_byte(8'hA0, -1, ack); check("glitch_dev_ack", 32'(ack), 32'd0);
    write_byte(8'h10, -1, ack); check("glitch_word_ack", 32'(ack), 32'd0);
    write_byte(8'h3C, 4, ack);  check("glitch_d0_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_q();
`endif

    check("end_wr_left", 32'(exp_wr.size()), 32'd0);
    check("end_rd_left", 32'(exp_rd.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
